// File: rtl/vga_timing_param_if.sv
// Timing-generator port bundle: the generator (master) takes en/restart and drives counters, flags and strobes.
// The drawing pipeline (slave) consumes the registered timing outputs.
interface vga_timing_param_if #(
    parameter int CNT_W = 11
);
    logic             en;
    logic             restart;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hblnk;
    logic             vblnk;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic             line_start;
    logic             frame_start;

    modport master (
        input  en, restart,
        output hcount, vcount, hblnk, vblnk, hsync, vsync, de, line_start, frame_start
    );

    modport slave (
        output en, restart,
        input  hcount, vcount, hblnk, vblnk, hsync, vsync, de, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_param.sv
// Parametrised VGA timing generator: pixel/line counters with blanking, sync, de and line/frame strobes.
// Outputs registered from next-count (aligned with hcount/vcount); en=0 freezes everything, restart wins over en.
module vga_timing_param #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter bit H_POL    = 1'b1,
    parameter bit V_POL    = 1'b1,
    parameter int CNT_W    = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vga_timing_param_if.master   tim_if
);
    localparam int HT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS0 = H_ACTIVE + H_FP;
    localparam int HS1 = HS0 + H_SYNC;
    localparam int VS0 = V_ACTIVE + V_FP;
    localparam int VS1 = VS0 + V_SYNC;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(HT - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(VT - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_S0   = CNT_W'(HS0);
    localparam logic [CNT_W-1:0] H_S1   = CNT_W'(HS1);
    localparam logic [CNT_W-1:0] V_S0   = CNT_W'(VS0);
    localparam logic [CNT_W-1:0] V_S1   = CNT_W'(VS1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [CNT_W-1:0] hcount_q, hcount_d;
    logic [CNT_W-1:0] vcount_q, vcount_d;
    logic             hblnk_q, hblnk_d;
    logic             vblnk_q, vblnk_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic             line_start_q, line_start_d;
    logic             frame_start_q, frame_start_d;

    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (tim_if.restart) begin
            hcount_d      = '0;
            vcount_d      = '0;
            line_start_d  = 1'b1;
            frame_start_d = 1'b1;
        end else if (tim_if.en) begin
            if (hcount_q == H_LAST) begin
                hcount_d     = '0;
                line_start_d = 1'b1;
                if (vcount_q == V_LAST) begin
                    vcount_d      = '0;
                    frame_start_d = 1'b1;
                end else begin
                    vcount_d = vcount_q + ONE;
                end
            end else begin
                hcount_d = hcount_q + ONE;
            end
        end

        // Flags derive from the next count so they land in the same cycle as the count they describe.
        hblnk_d = (hcount_d >= H_ACT);
        vblnk_d = (vcount_d >= V_ACT);
        hsync_d = ((hcount_d >= H_S0) && (hcount_d < H_S1)) ? H_POL : ~H_POL;
        vsync_d = ((vcount_d >= V_S0) && (vcount_d < V_S1)) ? V_POL : ~V_POL;
        de_d    = ~hblnk_d & ~vblnk_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            de_q          <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign tim_if.hcount      = hcount_q;
    assign tim_if.vcount      = vcount_q;
    assign tim_if.hblnk       = hblnk_q;
    assign tim_if.vblnk       = vblnk_q;
    assign tim_if.hsync       = hsync_q;
    assign tim_if.vsync       = vsync_q;
    assign tim_if.de          = de_q;
    assign tim_if.line_start  = line_start_q;
    assign tim_if.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_param.sv
// Bench for vga_timing_param: default 800x600, 640x480 (active-low syncs) and a tiny mode for whole-frame behaviour.
// A linear pixel-position model per instance is compared every cycle, plus directed literal checks.
module tb_vga_timing_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic restart = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    localparam int NI = 3;
    localparam int HA  [NI] = '{800, 640, 8};
    localparam int HFP [NI] = '{40, 16, 2};
    localparam int HSW [NI] = '{128, 96, 3};
    localparam int HBP [NI] = '{88, 48, 2};
    localparam int VA  [NI] = '{600, 480, 4};
    localparam int VFP [NI] = '{1, 10, 1};
    localparam int VSW [NI] = '{4, 2, 2};
    localparam int VBP [NI] = '{23, 33, 1};
    localparam bit HP  [NI] = '{1'b1, 1'b0, 1'b1};
    localparam bit VP  [NI] = '{1'b1, 1'b0, 1'b0};

    vga_timing_param_if #(.CNT_W(11)) if_def ();
    vga_timing_param_if #(.CNT_W(10)) if_640 ();
    vga_timing_param_if #(.CNT_W(4))  if_tiny ();

    assign if_def.en       = en;
    assign if_def.restart  = restart;
    assign if_640.en       = en;
    assign if_640.restart  = restart;
    assign if_tiny.en      = en;
    assign if_tiny.restart = restart;

    vga_timing_param u_def (.clk(clk), .rst_n(rst_n), .tim_if(if_def.master));

    vga_timing_param #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
        .H_POL(1'b0), .V_POL(1'b0), .CNT_W(10)
    ) u_640 (.clk(clk), .rst_n(rst_n), .tim_if(if_640.master));

    vga_timing_param #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b0), .CNT_W(4)
    ) u_tiny (.clk(clk), .rst_n(rst_n), .tim_if(if_tiny.master));

    typedef struct packed {
        bit [15:0] hc;
        bit [15:0] vc;
        bit hb, vb, hs, vs, de, ls, fs;
    } vt_t;

    function automatic int ht(int k);
        return HA[k] + HFP[k] + HSW[k] + HBP[k];
    endfunction

    function automatic int vtot(int k);
        return VA[k] + VFP[k] + VSW[k] + VBP[k];
    endfunction

    function automatic int tot(int k);
        return ht(k) * vtot(k);
    endfunction

    // Expected outputs for linear position p within the frame.
    function automatic vt_t expect_at(int k, int p, bit ls, bit fs);
        vt_t e;
        int h, v;
        h = p % ht(k);
        v = p / ht(k);
        e.hc = 16'(h);
        e.vc = 16'(v);
        e.hb = (h >= HA[k]);
        e.vb = (v >= VA[k]);
        e.hs = (h >= HA[k] + HFP[k] && h < HA[k] + HFP[k] + HSW[k]) ? HP[k] : !HP[k];
        e.vs = (v >= VA[k] + VFP[k] && v < VA[k] + VFP[k] + VSW[k]) ? VP[k] : !VP[k];
        e.de = !e.hb && !e.vb;
        e.ls = ls;
        e.fs = fs;
        return e;
    endfunction

    function automatic vt_t actual(int k);
        vt_t a;
        a = '0;
        case (k)
            0: begin
                a.hc = 16'(if_def.hcount); a.vc = 16'(if_def.vcount);
                a.hb = if_def.hblnk; a.vb = if_def.vblnk; a.hs = if_def.hsync; a.vs = if_def.vsync;
                a.de = if_def.de; a.ls = if_def.line_start; a.fs = if_def.frame_start;
            end
            1: begin
                a.hc = 16'(if_640.hcount); a.vc = 16'(if_640.vcount);
                a.hb = if_640.hblnk; a.vb = if_640.vblnk; a.hs = if_640.hsync; a.vs = if_640.vsync;
                a.de = if_640.de; a.ls = if_640.line_start; a.fs = if_640.frame_start;
            end
            default: begin
                a.hc = 16'(if_tiny.hcount); a.vc = 16'(if_tiny.vcount);
                a.hb = if_tiny.hblnk; a.vb = if_tiny.vblnk; a.hs = if_tiny.hsync; a.vs = if_tiny.vsync;
                a.de = if_tiny.de; a.ls = if_tiny.line_start; a.fs = if_tiny.frame_start;
            end
        endcase
        return a;
    endfunction

    int mp  [NI];
    bit mls [NI];
    bit mfs [NI];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                mp[k] <= 0; mls[k] <= 1'b0; mfs[k] <= 1'b0;
            end else if (restart) begin
                mp[k] <= 0; mls[k] <= 1'b1; mfs[k] <= 1'b1;
            end else if (en) begin
                mp[k]  <= (mp[k] + 1) % tot(k);
                mls[k] <= ((mp[k] + 1) % ht(k)) == 0;
                mfs[k] <= ((mp[k] + 1) % tot(k)) == 0;
            end else begin
                mls[k] <= 1'b0; mfs[k] <= 1'b0;
            end
        end
    end

    initial begin
        vt_t a, e;
        forever begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < NI; k++) begin
                a = actual(k);
                e = expect_at(k, mp[k], mls[k], mfs[k]);
                checks++;
                if (a != e) begin
                    errors++;
                    if (errors <= 20)
                        $display("FAIL model_cmp inst%0d cyc%0d got h=%0d v=%0d hb%0b vb%0b hs%0b vs%0b de%0b ls%0b fs%0b want h=%0d v=%0d hb%0b vb%0b hs%0b vs%0b de%0b ls%0b fs%0b",
                                 k, cyc, a.hc, a.vc, a.hb, a.vb, a.hs, a.vs, a.de, a.ls, a.fs,
                                 e.hc, e.vc, e.hb, e.vb, e.hs, e.vs, e.de, e.ls, e.fs);
                end
            end
        end
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int last, nfs, nvs, nvb;
        step(3);
        chk("rst_hcount", int'(if_def.hcount), 0);
        chk("rst_vcount", int'(if_def.vcount), 0);
        chk("rst_hblnk", int'(if_def.hblnk), 0);
        chk("rst_vblnk", int'(if_def.vblnk), 0);
        chk("rst_de", int'(if_def.de), 1);
        chk("rst_hsync", int'(if_def.hsync), 0);
        chk("rst_vsync", int'(if_def.vsync), 0);
        chk("rst_ls", int'(if_def.line_start), 0);
        chk("rst_fs", int'(if_def.frame_start), 0);
        chk("rst_640_hsync", int'(if_640.hsync), 1);
        chk("rst_640_vsync", int'(if_640.vsync), 1);
        chk("rst_tiny_vsync", int'(if_tiny.vsync), 1);

        rst_n = 1'b1;
        en    = 1'b1;
        step(1);
        chk("first_en_h", int'(if_def.hcount), 1);
        step(799);
        chk("h800", int'(if_def.hcount), 800);
        chk("h800_hblnk", int'(if_def.hblnk), 1);
        chk("h800_de", int'(if_def.de), 0);
        chk("h800_hsync", int'(if_def.hsync), 0);
        chk("640_wrap_h", int'(if_640.hcount), 0);
        chk("640_wrap_v", int'(if_640.vcount), 1);
        chk("640_wrap_ls", int'(if_640.line_start), 1);
        step(40);
        chk("h840_hsync", int'(if_def.hsync), 1);
        step(128);
        chk("h968_h", int'(if_def.hcount), 968);
        chk("h968_hsync", int'(if_def.hsync), 0);
        step(88);
        chk("wrap_h", int'(if_def.hcount), 0);
        chk("wrap_v", int'(if_def.vcount), 1);
        chk("wrap_ls", int'(if_def.line_start), 1);
        chk("wrap_fs", int'(if_def.frame_start), 0);

        step(10004);
        chk("pre_hold_h", int'(if_def.hcount), 500);
        chk("pre_hold_v", int'(if_def.vcount), 10);
        en = 1'b0;
        step(20);
        chk("hold_h", int'(if_def.hcount), 500);
        chk("hold_v", int'(if_def.vcount), 10);
        chk("hold_de", int'(if_def.de), 1);
        chk("hold_ls", int'(if_def.line_start), 0);
        en = 1'b1;
        step(1);
        chk("resume_h", int'(if_def.hcount), 501);

        en      = 1'b0;
        restart = 1'b1;
        step(1);
        chk("rs_h", int'(if_def.hcount), 0);
        chk("rs_v", int'(if_def.vcount), 0);
        chk("rs_ls", int'(if_def.line_start), 1);
        chk("rs_fs", int'(if_def.frame_start), 1);
        chk("rs_hsync", int'(if_def.hsync), 0);
        chk("rs_vsync", int'(if_def.vsync), 0);
        chk("rs_de", int'(if_def.de), 1);
        chk("rs_640_hsync", int'(if_640.hsync), 1);
        restart = 1'b0;
        step(1);
        chk("rs_hold_ls", int'(if_def.line_start), 0);
        chk("rs_hold_fs", int'(if_def.frame_start), 0);
        restart = 1'b1;
        step(1);
        chk("rs_again_fs", int'(if_def.frame_start), 1);
        restart = 1'b0;

        en = 1'b1;
        step(900);
        chk("pre_arst_h", int'(if_def.hcount), 900);
        chk("pre_arst_hsync", int'(if_def.hsync), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_h", int'(if_def.hcount), 0);
        chk("arst_hsync", int'(if_def.hsync), 0);
        chk("arst_hblnk", int'(if_def.hblnk), 0);
        chk("arst_de", int'(if_def.de), 1);
        chk("arst_640_h", int'(if_640.hcount), 0);
        chk("arst_640_v", int'(if_640.vcount), 0);
        @(negedge clk);
        rst_n = 1'b1;

        step(655);
        chk("640_h655_hsync", int'(if_640.hsync), 1);
        step(1);
        chk("640_h656", int'(if_640.hcount), 656);
        chk("640_h656_hsync", int'(if_640.hsync), 0);
        step(95);
        chk("640_h751_hsync", int'(if_640.hsync), 0);
        step(1);
        chk("640_h752_hsync", int'(if_640.hsync), 1);

        last = -1; nfs = 0; nvs = 0; nvb = 0;
        for (int i = 0; i < 360; i++) begin
            step(1);
            if (if_tiny.frame_start) begin
                if (last >= 0) chk("tiny_fs_period", i - last, 120);
                last = i;
                nfs++;
            end
            if (if_tiny.vsync == 1'b0) nvs++;
            if (if_tiny.vblnk) nvb++;
        end
        chk("tiny_fs_count", nfs, 3);
        chk("tiny_vsync_cycles", nvs, 90);
        chk("tiny_vblnk_cycles", nvb, 180);

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
